// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if
// Bundles the producer handshake, the FIFO write port and the arbiter
// status outputs that connect to fifo_wr_arbiter.
//
// Signals:
//   req_valid  producer -> arbiter  per-requester word valid
//   req_data   producer -> arbiter  requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  arbiter -> producer  per-requester accept, one-hot or zero
//   wfull      FIFO -> arbiter      FIFO full flag (write domain)
//   winc       arbiter -> FIFO      FIFO write enable
//   wdata      arbiter -> FIFO      FIFO write data
//   grant_id   arbiter -> observer  index of current or last owner
//   busy       arbiter -> observer  high while a grant is active
//
// Modports:
//   master  the arbiter side
//   slave   the producer/FIFO environment side
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = $clog2(NUM_REQ)
) ();

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          wfull;
  logic                          winc;
  logic [DATA_WIDTH-1:0]         wdata;
  logic [ID_W-1:0]               grant_id;
  logic                          busy;

  modport master (
    input  req_valid, req_data, wfull,
    output req_ready, winc, wdata, grant_id, busy
  );

  modport slave (
    output req_valid, req_data, wfull,
    input  req_ready, winc, wdata, grant_id, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Shares the single write port of the asynchronous FIFO among NUM_REQ
// producers. Grants are round-robin and bursted: the owner may write up to
// MAX_BURST words, then the arbiter returns to IDLE for one cycle and picks
// the next requester searching upward from the one after the last owner.
// The FIFO full flag stalls the owner without releasing it.
//
// Ports:
//   wclk_i    write-domain clock, the only clock
//   wrst_n_i  synchronous active-low reset, sampled on rising wclk_i
//   bus       fifo_wr_arbiter_if master modport (handshake, FIFO port, status)
//
// Build option:
//   FIFO_WR_ARB_HIPRI_EN  when defined, requester 0 wins every arbitration
//                         in which it is valid; otherwise pure round-robin.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic              wclk_i,
  input  logic              wrst_n_i,
  fifo_wr_arbiter_if.master bus
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e                state_q, state_d;
  logic [ID_W-1:0]       grant_id_q, grant_id_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;

  logic [ID_W-1:0]       sel_id;
  logic                  sel_found;
  logic                  owner_valid;
  logic [DATA_WIDTH-1:0] owner_data;
  logic                  active;
  logic                  beat;
  logic                  last_beat;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    if (id == ID_W'(NUM_REQ - 1)) return '0;
    return id + 1'b1;
  endfunction

  // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    sel_id    = '0;
    sel_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!sel_found && bus.req_valid[ID_W'(idx)]) begin
        sel_found = 1'b1;
        sel_id    = ID_W'(idx);
      end
    end
`ifdef FIFO_WR_ARB_HIPRI_EN
    if (bus.req_valid[0]) begin
      sel_found = 1'b1;
      sel_id    = '0;
    end
`endif
  end

  // Mux out the current owner's valid and data word.
  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == ID_W'(i)) begin
        owner_valid = bus.req_valid[i];
        owner_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Outputs drop as soon as reset is asserted, without waiting for an edge.
  assign active    = (state_q == GRANT) && wrst_n_i;
  assign beat      = active && owner_valid && !bus.wfull;
  assign last_beat = beat && (burst_cnt_q == CNT_W'(MAX_BURST - 1));

  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (active && grant_id_q == ID_W'(i)) bus.req_ready[i] = !bus.wfull;
    end
  end

  assign bus.winc     = beat;
  assign bus.wdata    = beat ? owner_data : '0;
  assign bus.grant_id = grant_id_q;
  assign bus.busy     = (state_q == GRANT);

  // Next-state: a grant ends on its last beat or when the owner drops valid;
  // a full FIFO alone never ends it. The counter stops at MAX_BURST-1.
  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d     = GRANT;
          grant_id_d  = sel_id;
          burst_cnt_d = '0;
        end
      end
      GRANT: begin
        if (beat && !last_beat) burst_cnt_d = burst_cnt_q + 1'b1;
        if (last_beat || !owner_valid) begin
          state_d  = IDLE;
          rr_ptr_d = next_id(grant_id_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk_i) begin
    if (!wrst_n_i) begin
      state_q     <= IDLE;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
// Self-checking bench for fifo_wr_arbiter: reset, a vector table covering
// short bursts, full stalls and re-arbitration, hand sequences for
// round-robin throughput, reset mid-burst and requester-0 priority, then
// randomized traffic against a cycle-level behavioural model.
module tb_fifo_wr_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MB = 4;
  localparam int IW = 2;

  logic wclk   = 1'b0;
  logic wrst_n = 1'b0;

  fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_W(IW)) bus ();

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB), .ID_W(IW)) dut (
    .wclk_i  (wclk),
    .wrst_n_i(wrst_n),
    .bus     (bus)
  );

  always #5 wclk = ~wclk;

  int testsRun  = 0;
  int failCount = 0;

  typedef struct {
    logic        rst_n;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        wfull;
    logic        expWinc;
    logic [3:0]  expReady;
    logic [7:0]  expWdata;
    logic        expBusy;
    logic [1:0]  expGid;
  } vec_t;

  vec_t vecs[13];

  // Behavioural model state: owner is -1 when no grant is active.
  int mOwner, mCnt, mRr, mGid;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst_n, input logic [3:0] valid,
                               input logic [31:0] data, input logic wfull);
    @(negedge wclk);
    wrst_n        = rst_n;
    bus.req_valid = valid;
    bus.req_data  = data;
    bus.wfull     = wfull;
  endtask

  task automatic checkOutput(input string name, input logic eWinc, input logic [3:0] eReady,
                             input logic [7:0] eWdata, input logic eBusy, input logic [1:0] eGid);
    #1;
    checkVal({name, ".winc"},  32'(bus.winc),      32'(eWinc));
    checkVal({name, ".ready"}, 32'(bus.req_ready), 32'(eReady));
    checkVal({name, ".wdata"}, 32'(bus.wdata),     32'(eWdata));
    checkVal({name, ".busy"},  32'(bus.busy),      32'(eBusy));
    checkVal({name, ".gid"},   32'(bus.grant_id),  32'(eGid));
  endtask

  function automatic logic bitAt(input logic [3:0] v, input int i);
    logic [1:0] s;
    s = 2'(i);
    return v[s];
  endfunction

  function automatic logic [7:0] wordAt(input logic [31:0] d, input int i);
    logic [31:0] t;
    t = d >> (i * 8);
    return t[7:0];
  endfunction

  task automatic modelOut(input logic rst_n, input logic [3:0] valid, input logic [31:0] data,
                          input logic wfull, output logic eWinc, output logic [3:0] eReady,
                          output logic [7:0] eWdata, output logic eBusy, output logic [1:0] eGid);
    eWinc  = 1'b0;
    eReady = 4'b0;
    eWdata = 8'h00;
    eBusy  = (mOwner >= 0);
    eGid   = 2'(mGid);
    if (rst_n && mOwner >= 0) begin
      eReady = 4'(!wfull) << mOwner;
      if (bitAt(valid, mOwner) && !wfull) begin
        eWinc  = 1'b1;
        eWdata = wordAt(data, mOwner);
      end
    end
  endtask

  task automatic modelStep(input logic rst_n, input logic [3:0] valid, input logic wfull);
    if (!rst_n) begin
      mOwner = -1;
      mCnt   = 0;
      mRr    = 0;
      mGid   = 0;
    end else if (mOwner < 0) begin
      int pick;
      pick = -1;
      for (int k = 0; k < NR; k++)
        if (pick < 0 && bitAt(valid, (mRr + k) % NR)) pick = (mRr + k) % NR;
`ifdef FIFO_WR_ARB_HIPRI_EN
      if (valid[0]) pick = 0;
`endif
      if (pick >= 0) begin
        mOwner = pick;
        mGid   = pick;
        mCnt   = 0;
      end
    end else begin
      logic took;
      took = bitAt(valid, mOwner) && !wfull;
      if (took) mCnt++;
      if ((took && mCnt == MB) || !bitAt(valid, mOwner)) begin
        mRr    = (mOwner + 1) % NR;
        mOwner = -1;
      end
    end
  endtask

  initial begin
    logic [7:0]  recData[$];
    logic [1:0]  recId[$];
    int          seq[4];
    int          wrSeq[4];
    logic [3:0]  pv;
    logic [31:0] pd;
    logic        pf, pr;
    logic        eWinc, eBusy;
    logic [3:0]  eReady;
    logic [7:0]  eWdata;
    logic [1:0]  eGid;
    logic [1:0]  wid;
    logic [7:0]  expWord;
    logic [1:0]  hipriGid;

    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.wfull     = 1'b0;

    // Reset held with every requester asking.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'hF, $urandom, 1'b0);
      checkOutput($sformatf("reset%0d", i), 1'b0, 4'h0, 8'h00, 1'b0, 2'd0);
    end

    // rst, valid, data, wfull | winc, ready, wdata, busy, gid
    vecs[0]  = '{1'b1, 4'b0100, 32'h00A0_0000, 1'b0, 1'b0, 4'b0000, 8'h00, 1'b0, 2'd0};
    vecs[1]  = '{1'b1, 4'b0100, 32'h00A0_0000, 1'b0, 1'b1, 4'b0100, 8'hA0, 1'b1, 2'd2};
    vecs[2]  = '{1'b1, 4'b0100, 32'h00A1_0000, 1'b0, 1'b1, 4'b0100, 8'hA1, 1'b1, 2'd2};
    vecs[3]  = '{1'b1, 4'b0000, 32'h0000_0000, 1'b0, 1'b0, 4'b0100, 8'h00, 1'b1, 2'd2};
    vecs[4]  = '{1'b1, 4'b0010, 32'h0000_B000, 1'b0, 1'b0, 4'b0000, 8'h00, 1'b0, 2'd2};
    vecs[5]  = '{1'b1, 4'b0010, 32'h0000_B000, 1'b0, 1'b1, 4'b0010, 8'hB0, 1'b1, 2'd1};
    vecs[6]  = '{1'b1, 4'b0010, 32'h0000_B100, 1'b1, 1'b0, 4'b0000, 8'h00, 1'b1, 2'd1};
    vecs[7]  = '{1'b1, 4'b0010, 32'h0000_B100, 1'b1, 1'b0, 4'b0000, 8'h00, 1'b1, 2'd1};
    vecs[8]  = '{1'b1, 4'b0010, 32'h0000_B100, 1'b0, 1'b1, 4'b0010, 8'hB1, 1'b1, 2'd1};
    vecs[9]  = '{1'b1, 4'b0010, 32'h0000_B200, 1'b0, 1'b1, 4'b0010, 8'hB2, 1'b1, 2'd1};
    vecs[10] = '{1'b1, 4'b0010, 32'h0000_B300, 1'b0, 1'b1, 4'b0010, 8'hB3, 1'b1, 2'd1};
    vecs[11] = '{1'b1, 4'b0010, 32'h0000_B400, 1'b0, 1'b0, 4'b0000, 8'h00, 1'b0, 2'd1};
    vecs[12] = '{1'b1, 4'b0010, 32'h0000_B400, 1'b0, 1'b1, 4'b0010, 8'hB4, 1'b1, 2'd1};

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].valid, vecs[i].data, vecs[i].wfull);
      checkOutput($sformatf("vec%0d", i), vecs[i].expWinc, vecs[i].expReady,
                  vecs[i].expWdata, vecs[i].expBusy, vecs[i].expGid);
    end

    // All four streaming: 16 words in 20 cycles, bursts in order 0..3.
    applyStimulus(1'b0, 4'h0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) seq[i] = 0;
    for (int c = 0; c < 20; c++) begin
      pd = '0;
      for (int i = 0; i < 4; i++) pd = pd | (32'((i << 6) | seq[i]) << (i * 8));
      applyStimulus(1'b1, 4'hF, pd, 1'b0);
      #1;
      if (bus.winc) begin
        recData.push_back(bus.wdata);
        recId.push_back(bus.grant_id);
      end
      for (int i = 0; i < 4; i++) if (bitAt(bus.req_ready, i)) seq[i]++;
    end
    checkVal("rr.count", 32'(recData.size()), 32'd16);
    for (int w = 0; w < recData.size() && w < 16; w++) begin
      expWord = 8'(((w / 4) << 6) | (w % 4));
      checkVal($sformatf("rr.id%0d", w), 32'(recId[w]), 32'(w / 4));
      checkVal($sformatf("rr.data%0d", w), 32'(recData[w]), 32'(expWord));
    end

    // Reset during requester 1's burst, after two words.
    applyStimulus(1'b0, 4'h0, 32'h0, 1'b0);
    applyStimulus(1'b1, 4'b0010, 32'h0000_C000, 1'b0);
    checkOutput("rstmid.idle", 1'b0, 4'h0, 8'h00, 1'b0, 2'd0);
    applyStimulus(1'b1, 4'b0010, 32'h0000_C000, 1'b0);
    checkOutput("rstmid.w0", 1'b1, 4'b0010, 8'hC0, 1'b1, 2'd1);
    applyStimulus(1'b1, 4'b0010, 32'h0000_C100, 1'b0);
    checkOutput("rstmid.w1", 1'b1, 4'b0010, 8'hC1, 1'b1, 2'd1);
    applyStimulus(1'b0, 4'b0010, 32'h0000_C200, 1'b0);
    checkOutput("rstmid.drop", 1'b0, 4'h0, 8'h00, 1'b1, 2'd1);
    applyStimulus(1'b1, 4'b0110, 32'h00D0_C200, 1'b0);
    checkOutput("rstmid.after", 1'b0, 4'h0, 8'h00, 1'b0, 2'd0);
    applyStimulus(1'b1, 4'b0110, 32'h00D0_C200, 1'b0);
    checkOutput("rstmid.regrant", 1'b1, 4'b0010, 8'hC2, 1'b1, 2'd1);

    // Priority: rr_ptr parked at 3, then requesters 0 and 3 both ask.
`ifdef FIFO_WR_ARB_HIPRI_EN
    hipriGid = 2'd0;
`else
    hipriGid = 2'd3;
`endif
    applyStimulus(1'b0, 4'h0, 32'h0, 1'b0);
    applyStimulus(1'b1, 4'b0100, 32'h00E0_0000, 1'b0);
    applyStimulus(1'b1, 4'b0100, 32'h00E0_0000, 1'b0);
    checkOutput("hipri.w", 1'b1, 4'b0100, 8'hE0, 1'b1, 2'd2);
    applyStimulus(1'b1, 4'b0000, 32'h0, 1'b0);
    applyStimulus(1'b1, 4'b1001, 32'hF000_00F1, 1'b0);
    checkOutput("hipri.idle", 1'b0, 4'h0, 8'h00, 1'b0, 2'd2);
    applyStimulus(1'b1, 4'b1001, 32'hF000_00F1, 1'b0);
    #1;
    checkVal("hipri.gid", 32'(bus.grant_id), 32'(hipriGid));

    // Randomized traffic checked against the model and per-requester order.
    applyStimulus(1'b0, 4'h0, 32'h0, 1'b0);
    modelStep(1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      seq[i]   = 0;
      wrSeq[i] = 0;
    end
    pv = 4'h0;
    eReady = 4'h0;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (bitAt(pv, i) && bitAt(eReady, i)) seq[i]++;
        if (bitAt(pv, i) && !bitAt(eReady, i))
          pv[2'(i)] = ($urandom_range(0, 7) != 0);
        else
          pv[2'(i)] = ($urandom_range(0, 3) != 0);
      end
      pd = '0;
      for (int i = 0; i < 4; i++) pd = pd | (32'((i << 6) | (seq[i] & 63)) << (i * 8));
      pf = ($urandom_range(0, 4) == 0);
      pr = ($urandom_range(0, 99) != 0);
      applyStimulus(pr, pv, pd, pf);
      modelOut(pr, pv, pd, pf, eWinc, eReady, eWdata, eBusy, eGid);
      checkOutput($sformatf("rnd%0d", c), eWinc, eReady, eWdata, eBusy, eGid);
      if (bus.winc) begin
        wid = bus.wdata[7:6];
        checkVal($sformatf("rnd%0d.order", c), 32'(bus.wdata[5:0]), 32'(wrSeq[wid] & 63));
        wrSeq[wid]++;
      end
      modelStep(pr, pv, pf);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
